fp_normalize_round: RTL and testbench
=====================================

// Module: fp_normalize_round
// PURPOSE
//  Post-adder stage for the IEEE-754 single-precision add/sub datapath.
//  Takes the raw, unnormalized sum from the add/sub mantissa stage and produces the packed 32-bit result.
//  Raw sum = sign, wide exponent, carry/hidden/fraction/GRS mantissa, special flags.
//  Normalizes in both directions, rounds to nearest-even, detects over/underflow and packs the result.
//  Two-stage pipeline with valid/ready flow control on both sides.
// PARAMETERS
//  EXP_W   8    stored exponent width (bias = 2**(EXP_W-1)-1 = 127)
//  FRAC_W  23   stored fraction width
//  EW      10   internal signed exponent width (EXP_W+2)
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst_n         in   1         synchronous reset, active low
//  in_valid      in   1         upstream raw sum valid
//  in_ready      out  1         stage can accept in_* this cycle
//  in_sign       in   1         result sign
//  in_exp        in   EW        biased exponent, two's complement, of the larger operand
//  in_mant       in   FRAC_W+5  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=sticky
//  in_zero       in   1         operands cancelled exactly / both zero
//  in_inf        in   1         result is infinity (sign = in_sign)
//  in_nan        in   1         result is NaN (priority over in_inf/in_zero)
//  out_valid     out  1         out_* valid
//  out_ready     in   1         downstream accepts out_* this cycle
//  out_result    out  32        packed IEEE-754 single
//  out_overflow  out  1         finite input rounded to infinity
//  out_underflow out  1         nonzero result flushed to zero
//  out_inexact   out  1         any discarded nonzero bit (G|R|S after normalize) or over/underflow
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): both stage valids cleared. out_valid=0, out_result=0, all flags=0.
//   Reset in mid-operation discards in-flight data; in_ready=1 on the first cycle after release.
//  Handshake: transfer on valid&ready at a clock edge.
//   out_valid/out_* hold stable while out_valid & !out_ready.
//   in_ready = !s1_valid | (!s2_valid | out_ready); no combinational in_valid->in_ready path.
//  Latency 2 cycles from input transfer to out_valid with out_ready held high; throughput 1/cycle.
//  Stage 1 (normalize):
//   - mant[27]=1: shift right 1, old bit0 ORed into sticky; exp+1.
//   - else: lzc = leading zeros of mant[26:3]; shift left lzc (GRS shift in alongside); exp-lzc.
//   - mant[26:0]=0 and no carry: treat as in_zero.
//  Stage 2 (round/pack):
//   - RNE: inc = G & (R | S | lsb). Mantissa carry from rounding -> exp+1, fraction=0.
//   - exp >= 255 after rounding: +/-inf (exp=8'hFF, frac=0); overflow=1, inexact=1.
//   - exp <= 0: signed zero, no subnormals produced; underflow=1, inexact=1.
//  Special-case priority: nan > inf > zero > normal.
//   - nan: 32'h7FC00000, no flags.
//   - inf: {in_sign,8'hFF,23'h0}, no flags.
//   - zero: {in_sign,31'h0}, no flags.
//  Width rule: all exponent arithmetic is EW-bit signed; no wrap for any in_exp in [-64,383].
// TESTING
//  1 1.0+1.0: exp=127, mant=28'h8000000 -> 2 cycles later 32'h40000000, flags 0.
//  2 Cancellation: exp=127, mant=28'h0000008 -> 32'h34000000 (exp 104), flags 0.
//  3 RNE: exp=127, mant={2'b01,23'h0,3'b100} -> 32'h3F800000, inexact=1.
//    Same with frac=23'h1 -> 32'h3F800002, inexact=1.
//  4 Overflow: exp=254, mant=28'h8000000 -> 32'h7F800000, overflow=1, inexact=1.
//    exp=254, mant={2'b01,23'h7FFFFF,3'b110} -> 32'h7F800000, overflow=1.
//  5 Backpressure: out_ready=0, 3 inputs offered back-to-back -> 2 accepted, in_ready=0, out_result stable.
//    Release -> all 3 results in order, none dropped or duplicated.
//  6 Reset with 2 in flight -> out_valid=0 next cycle, no stale output after release.
//    Also: in_nan & in_inf -> 32'h7FC00000.

Source files
------------

// File: rtl/fp_normalize_round.sv
// Post-adder normalize/round/pack stage for single-precision add/sub.
// Stage 1 normalizes the raw sum, stage 2 rounds to nearest-even and packs the IEEE word.
module fp_normalize_round #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned EW     = EXP_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EW-1:0]           in_exp,
  input  logic [FRAC_W+4:0]       in_mant,
  input  logic                    in_zero,
  input  logic                    in_inf,
  input  logic                    in_nan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  localparam int unsigned MW    = FRAC_W + 5;
  localparam int unsigned NW    = FRAC_W + 4;
  localparam int unsigned SW    = FRAC_W + 1;
  localparam int unsigned RSW   = SW + 1;
  localparam int unsigned LZW   = $clog2(SW + 1);
  localparam int unsigned FWM1  = FRAC_W - 1;
  localparam int unsigned MAGW  = EXP_W + FRAC_W;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q, s1_sign_d;
  logic signed [EW-1:0]   s1_exp_q, s1_exp_d;
  logic [NW-1:0]          s1_mant_q, s1_mant_d;
  logic                   s1_zero_q, s1_zero_d;
  logic                   s1_inf_q, s1_inf_d;
  logic                   s1_nan_q, s1_nan_d;

  logic                   out_valid_q, out_valid_d;
  logic [MAGW:0]          out_result_q, out_result_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_unf_q, out_unf_d;
  logic                   out_inx_q, out_inx_d;

  logic                   s1_adv;
  logic [LZW-1:0]         lzc;
  logic                   rnd_inc;
  logic [RSW-1:0]         rsum;
  logic signed [EW-1:0]   rexp;
  logic [FRAC_W-1:0]      rfrac;
  logic                   grs_nz;

  // Stage 2 drains whenever it is empty or being consumed; stage 1 then refills.
  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  // Leading-zero count over hidden+fraction; the last hit walking upward is the MSB.
  always_comb begin
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (in_mant[i+3]) lzc = LZW'(SW - 1 - i);
    end
  end

  // Stage 1: normalize right on carry, otherwise left by the leading-zero count.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_ready && in_valid) begin
      s1_sign_d = in_sign;
      s1_nan_d  = in_nan;
      s1_inf_d  = in_inf;
      s1_zero_d = in_zero || (in_mant == '0);
      if (in_mant[MW-1]) begin
        s1_mant_d = {in_mant[MW-1:2], in_mant[1] | in_mant[0]};
        s1_exp_d  = in_exp + EW'(1);
      end else begin
        s1_mant_d = in_mant[NW-1:0] << lzc;
        s1_exp_d  = in_exp - EW'(lzc);
      end
    end
  end

  // Round to nearest-even; a rounding carry renormalizes by one place.
  always_comb begin
    grs_nz  = |s1_mant_q[2:0];
    rnd_inc = s1_mant_q[2] & (s1_mant_q[1] | s1_mant_q[0] | s1_mant_q[3]);
    rsum    = {1'b0, s1_mant_q[NW-1:3]} + RSW'(rnd_inc);
    rexp    = s1_exp_q + EW'(rsum[SW]);
    rfrac   = rsum[SW] ? rsum[SW-1:1] : rsum[SW-2:0];
  end

  // Stage 2: special-case priority, then overflow/underflow, then normal pack.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_unf_d    = out_unf_q;
    out_inx_d    = out_inx_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ovf_d = 1'b0;
        out_unf_d = 1'b0;
        out_inx_d = 1'b0;
        if (s1_nan_q) begin
          out_result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {FWM1{1'b0}}};
        end else if (s1_inf_q) begin
          out_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (s1_zero_q) begin
          out_result_d = {s1_sign_q, {MAGW{1'b0}}};
        end else if (rexp >= EXP_MAX) begin
          out_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          out_ovf_d    = 1'b1;
          out_inx_d    = 1'b1;
        end else if (rexp <= EXP_ZERO) begin
          out_result_d = {s1_sign_q, {MAGW{1'b0}}};
          out_unf_d    = 1'b1;
          out_inx_d    = 1'b1;
        end else begin
          out_result_d = {s1_sign_q, rexp[EXP_W-1:0], rfrac};
          out_inx_d    = grs_nz;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_zero_q    <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_nan_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
      out_inx_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_zero_q    <= s1_zero_d;
      s1_inf_q     <= s1_inf_d;
      s1_nan_q     <= s1_nan_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_unf_q    <= out_unf_d;
      out_inx_q    <= out_inx_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = out_ovf_q;
  assign out_underflow = out_unf_q;
  assign out_inexact   = out_inx_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vectors, flow-control/reset sequences,
// and random traffic checked against an integer-arithmetic rounding model.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_result;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        ix;
  } out_t;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] mant;
    logic        z, inf, nan;
    out_t        exp_out;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_popped = 0;
  out_t exp_q[$];
  logic hold_pending = 1'b0;
  out_t hold_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Value is mant * 2^(exp-127-26); normalize to a 24-bit significand and round RNE on the remainder.
  function automatic out_t model(input logic sign, input int e_in, input logic [27:0] mant,
                                 input logic z, input logic inf, input logic nan);
    out_t   o;
    longint keep, rem, half;
    int     p, sh, e;
    o = '0;
    if (nan) o.res = 32'h7FC00000;
    else if (inf) o.res = {sign, 8'hFF, 23'h0};
    else if (z || mant == 28'h0) o.res = {sign, 31'h0};
    else begin
      p = 0;
      for (int i = 0; i < 28; i++) if (mant[i]) p = i;
      e  = e_in + p - 26;
      sh = p - 23;
      if (sh > 0) begin
        keep = longint'(mant) >> sh;
        rem  = longint'(mant) & ((64'sd1 << sh) - 1);
        half = 64'sd1 << (sh - 1);
      end else begin
        keep = longint'(mant) << (-sh);
        rem  = 0;
        half = 1;
      end
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'sd1 << 24)) begin
        keep = keep >> 1;
        e++;
      end
      o.ix = (rem != 0);
      if (e >= 255) begin
        o.res = {sign, 8'hFF, 23'h0};
        o.ov  = 1'b1;
        o.ix  = 1'b1;
      end else if (e <= 0) begin
        o.res = {sign, 31'h0};
        o.un  = 1'b1;
        o.ix  = 1'b1;
      end else o.res = {sign, 8'(e), 23'(keep)};
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic s, input int e, input logic [27:0] m, input logic z,
                              input logic inf, input logic nan, input logic [31:0] r,
                              input logic ov, input logic un, input logic ix);
    vec_t v;
    v.sign = s; v.exp = 10'(e); v.mant = m; v.z = z; v.inf = inf; v.nan = nan;
    v.exp_out = {r, ov, un, ix};
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   edges[6];
    int   r;
    edges = '{-64, 1, 2, 253, 254, 383};
    v.sign = 1'($urandom);
    if ($urandom_range(0, 3) == 0) v.exp = 10'(edges[$urandom_range(0, 5)]);
    else v.exp = 10'(int'($urandom_range(0, 447)) - 64);
    v.mant = 28'($urandom) >> $urandom_range(0, 24);
    if (v.mant[27:3] == 25'h0) v.mant[3] = 1'b1;
    r = int'($urandom_range(0, 19));
    v.nan = (r == 0);
    v.inf = (r == 0 || r == 1);
    v.z   = (r == 2 || r == 0);
    v.exp_out = model(v.sign, int'($signed(v.exp)), v.mant, v.z, v.inf, v.nan);
    return v;
  endfunction

  task automatic drive(input logic v, input vec_t x);
    in_valid = v;
    in_sign  = x.sign;
    in_exp   = x.exp;
    in_mant  = x.mant;
    in_zero  = x.z;
    in_inf   = x.inf;
    in_nan   = x.nan;
  endtask

  // One cycle of streaming: drive, then check hold-stability, consumed output and input acceptance.
  task automatic step(input logic v, input vec_t x, input logic ordy, output logic accepted);
    out_t cur;
    @(negedge clk);
    drive(v, x);
    out_ready = ordy;
    #1;
    cur = {out_result, out_overflow, out_underflow, out_inexact};
    if (hold_pending) check("hold_stable", {out_valid, cur}, {1'b1, hold_val});
    hold_pending = out_valid && !out_ready;
    hold_val     = cur;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_output", {1'b1, cur}, 64'h0);
      else check("stream_result", cur, exp_q.pop_front());
      n_popped++;
    end
    accepted = v && in_ready;
    if (accepted) exp_q.push_back(model(x.sign, int'($signed(x.exp)), x.mant, x.z, x.inf, x.nan));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    vec_t bp[3];
    vec_t idle;
    logic acc;
    int   cycles, idx, popped0;

    tbl[0]  = mk(0, 127, 28'h8000000, 0, 0, 0, 32'h40000000, 0, 0, 0);
    tbl[1]  = mk(0, 127, 28'h0000008, 0, 0, 0, 32'h34000000, 0, 0, 0);
    tbl[2]  = mk(0, 127, 28'h4000004, 0, 0, 0, 32'h3F800000, 0, 0, 1);
    tbl[3]  = mk(0, 127, 28'h400000C, 0, 0, 0, 32'h3F800002, 0, 0, 1);
    tbl[4]  = mk(0, 254, 28'h8000000, 0, 0, 0, 32'h7F800000, 1, 0, 1);
    tbl[5]  = mk(0, 254, 28'h7FFFFFE, 0, 0, 0, 32'h7F800000, 1, 0, 1);
    tbl[6]  = mk(1, 127, 28'h4000000, 0, 1, 1, 32'h7FC00000, 0, 0, 0);
    tbl[7]  = mk(1, 127, 28'h4000000, 0, 1, 0, 32'hFF800000, 0, 0, 0);
    tbl[8]  = mk(1, 127, 28'h4000000, 1, 0, 0, 32'h80000000, 0, 0, 0);
    tbl[9]  = mk(0, 100, 28'h0000000, 0, 0, 0, 32'h00000000, 0, 0, 0);
    tbl[10] = mk(1, 1,   28'h0000008, 0, 0, 0, 32'h80000000, 0, 1, 1);
    tbl[11] = mk(0, -64, 28'h8000000, 0, 0, 0, 32'h00000000, 0, 1, 1);
    tbl[12] = mk(0, 383, 28'h4000000, 0, 0, 0, 32'h7F800000, 1, 0, 1);
    tbl[13] = mk(0, 1,   28'h4000000, 0, 0, 0, 32'h00800000, 0, 0, 0);
    tbl[14] = mk(0, 127, 28'h8000001, 0, 0, 0, 32'h40000000, 0, 0, 1);
    tbl[15] = mk(0, 127, 28'h8000018, 0, 0, 0, 32'h40000002, 0, 0, 1);
    idle = tbl[0];

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, idle);
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact},
          {1'b1, 1'b0, 32'h0, 3'b000});
    rst_n = 1'b1;

    // Directed vectors: fixed expectations and two-cycle latency.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i]);
      @(negedge clk);
      in_valid = 1'b0;
      cycles = 1;
      while (!out_valid && cycles < 10) begin
        @(negedge clk);
        cycles++;
      end
      check($sformatf("vec%0d_latency", i), 64'(cycles), 64'd2);
      check($sformatf("vec%0d_result", i), {out_result, out_overflow, out_underflow, out_inexact},
            tbl[i].exp_out);
    end

    // Backpressure: three offered, two accepted, output held, then all three drain in order.
    @(negedge clk);
    bp[0] = tbl[0]; bp[1] = tbl[3]; bp[2] = tbl[13];
    idx = 0;
    popped0 = n_popped;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, bp[idx < 3 ? idx : 0], 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready", {63'h0, in_ready}, 64'h0);
    for (int c = 0; c < 12 && !(idx == 3 && exp_q.size() == 0); c++) begin
      step(idx < 3, bp[idx < 3 ? idx : 0], 1'b1, acc);
      if (acc) idx++;
    end
    check("bp_drained", 64'(n_popped - popped0), 64'd3);

    // Reset with two results in flight.
    idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      step(1'b1, tbl[1], 1'b0, acc);
      if (acc) idx++;
    end
    step(1'b0, idle, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_reset_state", {in_ready, out_valid, out_result}, {1'b1, 1'b0, 32'h0});
    rst_n = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, idle, 1'b1, acc);
    check("post_reset_idle", {63'h0, out_valid}, 64'h0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, idle, 1'b1, acc);
    check("random_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
